iqmap_bpsk: RTL
===============

Name: iqmap_bpsk

Overview:
- Transmit-side BPSK mapper. Reads 128-bit payload words from the TX memory FIFO and maps each bit onto one subcarrier as ±AMP real, 0 imaginary.
- Emits two contiguous 64-sample frequency-domain symbols per word to the IFFT stage, in natural carrier order.
- Sits between the TX payload FIFO and ifft64, mirroring iqdemap_bpsk on the receive side.

Parameters:
- width, 11, bit width of xr/xi (signed two's complement).
- AMP, 256, magnitude of a mapped carrier; must satisfy 0 < AMP < 2^(width-1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- empty  in  1  source FIFO empty.
- rd_en  out  1  source FIFO read strobe; data appears on din the cycle after.
- din  in  128  payload word; bits [63:0] form symbol 0, bits [127:64] form symbol 1.
- ce  in  1  downstream accept/clock-enable; output advances only when ce=1.
- valid_o  out  1  xr/xi hold a valid sample.
- xr  out  width  real part.
- xi  out  width  imaginary part, always 0.
- sym_start  out  1  high with valid_o on carrier 0 of every symbol.
- busy  out  1  a word is being emitted or is buffered.

Behaviour:
- Reset (RST=0, async): valid_o=0, rd_en=0, xr=0, xi=0, sym_start=0, busy=0. Index, cur_valid, nxt_valid and rd_pend are cleared; any word in flight is discarded. Release is synchronous to CLK.
- Buffering: two 128-bit registers, cur and nxt, with flags cur_valid and nxt_valid.
  - rd_en is combinational: rd_en = !empty & !nxt_valid & !rd_pend.
  - rd_pend is set on rd_en; on the next cycle din is captured into nxt, nxt_valid is set and rd_pend is cleared.
- Transfer rule: nxt moves to cur (nxt_valid cleared) when either:
  - cur_valid=0, or
  - the last sample (idx=127) is accepted.
  This gives gapless back-to-back words whenever the FIFO keeps up.
- Emission:
  - 7-bit idx walks 0..127; bit = cur[idx].
  - Registered output: xr = bit ? +AMP : -AMP; xi = 0.
  - valid_o = cur_valid; sym_start = valid_o & (idx[5:0]==0).
  - Output latency: 1 cycle from cur becoming valid to the first sample.
- Handshake:
  - A sample is consumed on a cycle with valid_o & ce.
  - While ce=0, xr, xi, valid_o, sym_start and idx hold unchanged.
  - Prefetch continues while stalled.
- FSM states:
  - IDLE (cur_valid=0) goes to EMIT when nxt transfers in.
  - EMIT stays in EMIT at idx=127 if nxt_valid (or nxt is arriving this cycle), otherwise returns to IDLE.
- idx wraps 127→0 on the last accept; symbol boundary at idx 63→64.
- busy = cur_valid | nxt_valid | rd_pend.
- Simultaneous events:
  - When capture into nxt and transfer nxt→cur fall in the same cycle, din goes straight to cur.
  - empty is not reevaluated after rd_en until rd_pend clears.
- The FIFO can never be overread: at most one outstanding read, and only when nxt is free.

Optional Feature:
- Macro IQMAP_DCNULL_EN.
- Defined: carriers with idx[5:0]==0 are forced to xr=0, xi=0 (DC null). The corresponding payload bits (din[0] and din[64]) are ignored. sym_start timing is unchanged.
- Undefined: every carrier carries data, including DC.

Decomposition:
- Shared package comm_pkg: COMM_WIDTH=11, COMM_NCARR=64, COMM_WORD=128, BPSK_AMP=256, and the FSM state typedef {IDLE, EMIT}. This package is shared with iqdemap_bpsk.
- One natural sub-module, iqmap_prefetch: holds nxt, rd_pend and the rd_en logic, and exposes a valid/take handshake to the mapper core.

Test Plan:
- Single word din=128'h0000_0000_0000_0001_8000_0000_0000_0000, ce=1 → 128 samples.
  - Sample 0 = -256; sample 63 = +256; sample 64 = +256; all others -256.
  - sym_start high at samples 0 and 64; then valid_o=0 and busy=0.
- Three words queued, ce=1 constantly → 384 consecutive valid_o cycles with no gap; rd_en pulses exactly 3 times.
- ce toggles 1/0 every cycle on word 128'hAAAA...A → exactly 128 accepted samples; xr alternates -256/+256 across accepts and holds stable during ce=0.
- empty=1 throughout → rd_en never asserts; valid_o=0; busy=0.
- RST pulled low at sample 40 of word 1 → outputs zero asynchronously. After release with FIFO refilled, emission restarts at idx 0 of a freshly read word.
- With IQMAP_DCNULL_EN, din=all-ones → samples 0 and 64 are 0; all others +256.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared constants and FSM state type for the BPSK IQ mapper and demapper.
package comm_pkg;

   localparam int COMM_WIDTH = 11;
   localparam int COMM_NCARR = 64;
   localparam int COMM_WORD  = 128;
   localparam int BPSK_AMP   = 256;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/iqmap_prefetch.sv
// One-word prefetch buffer in front of the mapper core: at most one outstanding FIFO read, issued only when nxt is free.
// Read data is offered one cycle after rd_en; a take in that same cycle passes din straight through, bypassing nxt.
module iqmap_prefetch
   import comm_pkg::*;
#(
   parameter int WORD = COMM_WORD
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            empty,
   output logic            rd_en,
   input  logic [WORD-1:0] din,
   output logic            avail,
   output logic [WORD-1:0] dat,
   input  logic            take
);

   logic [WORD-1:0] nxt;
   logic            nxt_valid;
   logic            rd_pend;

   // Gated by reset so the FIFO is never strobed while the block is held in reset.
   assign rd_en = rst_n && !empty && !nxt_valid && !rd_pend;

   // rd_pend and nxt_valid are mutually exclusive: a read is only issued while nxt is free.
   assign avail = nxt_valid || rd_pend;
   assign dat   = nxt_valid ? nxt : din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         nxt_valid <= 1'b0;
         nxt       <= '0;
      end else begin
         rd_pend <= rd_en;
         if (rd_pend && !take) begin
            nxt       <= din;
            nxt_valid <= 1'b1;
         end else if (take) begin
            nxt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/iqmap_bpsk.sv
// BPSK mapper: each payload bit becomes one carrier at +/-AMP, two 64-carrier symbols per word, output advances only on ce.
// With IQMAP_DCNULL_EN defined, carrier 0 of every symbol is forced to zero.
module iqmap_bpsk
   import comm_pkg::*;
#(
   parameter int width = COMM_WIDTH,
   parameter int AMP   = BPSK_AMP
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    empty,
   output logic                    rd_en,
   input  logic [COMM_WORD-1:0]    din,
   input  logic                    ce,
   output logic                    valid_o,
   output logic signed [width-1:0] xr,
   output logic signed [width-1:0] xi,
   output logic                    sym_start,
   output logic                    busy
);

   localparam int IDXW = $clog2(COMM_WORD);
   localparam int CW   = $clog2(COMM_NCARR);
   localparam logic signed [width-1:0] AMP_P = AMP[width-1:0];
   localparam logic signed [width-1:0] AMP_N = -AMP_P;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(COMM_WORD - 1);

   logic                    pf_avail;
   logic [COMM_WORD-1:0]    pf_dat;
   logic                    take;

   state_t                  state, state_d;
   logic [COMM_WORD-1:0]    cur, cur_d;
   logic [IDXW-1:0]         idx, idx_d;
   logic signed [width-1:0] xr_d;
   logic                    sym_d;
   logic                    accept;
   logic                    last;

   iqmap_prefetch #(
      .WORD (COMM_WORD)
   ) u_prefetch (
      .clk   (CLK),
      .rst_n (RST),
      .empty (empty),
      .rd_en (rd_en),
      .din   (din),
      .avail (pf_avail),
      .dat   (pf_dat),
      .take  (take)
   );

   assign accept = (state == EMIT) && ce;
   assign last   = accept && (idx == IDX_LAST);
   assign take   = pf_avail && ((state == IDLE) || last);

   // cur is shifted down on every accept so the presented bit is always cur[0]; idx tracks the carrier number.
   always_comb begin
      state_d = state;
      cur_d   = cur;
      idx_d   = idx;
      xr_d    = xr;
      sym_d   = sym_start;

      if (take) begin
         state_d = EMIT;
         cur_d   = pf_dat;
         idx_d   = '0;
      end else if (last) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (accept) begin
         cur_d = cur >> 1;
         idx_d = idx + IDXW'(1);
      end

      if (take || accept) begin
         if (state_d == EMIT) begin
            xr_d  = cur_d[0] ? AMP_P : AMP_N;
            sym_d = (idx_d[CW-1:0] == '0);
`ifdef IQMAP_DCNULL_EN
            if (idx_d[CW-1:0] == '0) begin
               xr_d = '0;
            end
`endif
         end else begin
            xr_d  = '0;
            sym_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         cur       <= '0;
         idx       <= '0;
         xr        <= '0;
         sym_start <= 1'b0;
      end else begin
         state     <= state_d;
         cur       <= cur_d;
         idx       <= idx_d;
         xr        <= xr_d;
         sym_start <= sym_d;
      end
   end

   assign valid_o = (state == EMIT);
   assign xi      = '0;
   assign busy    = (state == EMIT) || pf_avail;

endmodule
